// File: rtl/pseudoinverse_pkg.sv
// Shared constants for the pseudoinverse inner-product datapath: default
// operand width and Q format, accumulator guard width, and the signed
// saturation bounds used when results are clipped.
package pseudoinverse_pkg;

    localparam int DEFAULT_NBITS     = 32;
    localparam int DEFAULT_FRAC_BITS = 16;

    // Extra accumulator bits above the full product width; 4 bits lets
    // 16 worst-case products be summed without wrapping.
    localparam int ACC_GUARD_BITS    = 4;

    // Largest and smallest value representable in an n-bit signed result.
    function automatic longint sat_hi(input int n);
        return (longint'(1) <<< (n - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int n);
        return -(longint'(1) <<< (n - 1));
    endfunction

    localparam longint SAT_HI_DEFAULT = sat_hi(DEFAULT_NBITS);
    localparam longint SAT_LO_DEFAULT = sat_lo(DEFAULT_NBITS);

endpackage

// File: rtl/dot_product_mult.sv
// Stage 1 of the dot-product pipeline: registers the full-width signed
// product of the two operand memory words and tags it as valid / last.
module dot_product_mult
    import pseudoinverse_pkg::*;
#(
    parameter int nBits = DEFAULT_NBITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [nBits-1:0]      rd_data_a,
    input  logic [nBits-1:0]      rd_data_b,
    input  logic                  enableff,
    input  logic                  flag,
    output logic [2*nBits-1:0]    prod,
    output logic                  p_valid,
    output logic                  p_last
);

    logic signed [2*nBits-1:0] prod_full;

    // Both operands are sign-extended to the product width before the multiply.
    always_comb begin
        prod_full = (2*nBits)'($signed(rd_data_a)) * (2*nBits)'($signed(rd_data_b));
    end

    // Capture a product whenever the controller retires an element; flag wins over enableff.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod    <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else if (enableff || flag) begin
            prod    <= prod_full;
            p_valid <= 1'b1;
            p_last  <= flag;
        end else begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Fixed-point dot-product accumulator fed by the inner-product control
// generator. Stage 1 (dot_product_mult) multiplies, stage 2 accumulates and
// finalizes into a valid/ready result register.
// Optional feature: define DOT_SATURATE_EN to clip results to the signed
// nBits range and report clipping on 'sat'; otherwise results wrap.
module dot_product_accumulator
    import pseudoinverse_pkg::*;
#(
    parameter int nBits     = DEFAULT_NBITS,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [nBits-1:0]  position,
    input  logic              clearff,
    input  logic              enableff,
    input  logic              flag,
    output logic [nBits-1:0]  addr,
    input  logic [nBits-1:0]  rd_data_a,
    input  logic [nBits-1:0]  rd_data_b,
    output logic [nBits-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              overrun,
    output logic              sat
);

    localparam int PROD_W = 2 * nBits;
    localparam int ACC_W  = PROD_W + ACC_GUARD_BITS;

    logic [PROD_W-1:0]       prod;
    logic                    p_valid;
    logic                    p_last;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic [nBits-1:0]        fmt_value;
    logic                    finalize;
    logic                    consume;

    assign addr = position;

    dot_product_mult #(
        .nBits(nBits)
    ) u_mult (
        .clk      (clk),
        .reset    (reset),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .enableff (enableff),
        .flag     (flag),
        .prod     (prod),
        .p_valid  (p_valid),
        .p_last   (p_last)
    );

    // Running sum including the product currently leaving stage 1.
    always_comb begin
        acc_sum = acc + $signed({{ACC_GUARD_BITS{prod[PROD_W-1]}}, prod});
    end

    assign finalize = p_valid && p_last;
    assign consume  = result_valid && result_ready;

`ifdef DOT_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI_ACC = ACC_W'(sat_hi(nBits));
    localparam logic signed [ACC_W-1:0] SAT_LO_ACC = ACC_W'(sat_lo(nBits));
    localparam logic [nBits-1:0]        SAT_HI_RES = nBits'(sat_hi(nBits));
    localparam logic [nBits-1:0]        SAT_LO_RES = nBits'(sat_lo(nBits));

    logic signed [ACC_W-1:0] shifted;
    logic                    fmt_clip;

    // Rescale to Q format and clip anything outside the signed result range.
    always_comb begin
        shifted   = acc_sum >>> FRAC_BITS;
        fmt_value = shifted[nBits-1:0];
        fmt_clip  = 1'b0;
        if (shifted > SAT_HI_ACC) begin
            fmt_value = SAT_HI_RES;
            fmt_clip  = 1'b1;
        end else if (shifted < SAT_LO_ACC) begin
            fmt_value = SAT_LO_RES;
            fmt_clip  = 1'b1;
        end
    end

    // sat describes the most recent result only, so it is rewritten at each finalization.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat <= 1'b0;
        end else if (finalize) begin
            sat <= fmt_clip;
        end
    end
`else
    // Rescale to Q format and keep the low nBits (two's complement wrap).
    always_comb begin
        fmt_value = nBits'(acc_sum >>> FRAC_BITS);
    end

    assign sat = 1'b0;
`endif

    // Accumulate products; clearff only acts when no product is in flight so a draining element is never dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (p_valid) begin
            acc <= p_last ? '0 : acc_sum;
        end else if (clearff) begin
            acc <= '0;
        end
    end

    // Result register with valid/ready handshake; a finalization always wins over a consume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (finalize) begin
            result       <= fmt_value;
            result_valid <= 1'b1;
            if (result_valid && !result_ready) begin
                overrun <= 1'b1;
            end
        end else if (consume) begin
            result_valid <= 1'b0;
        end
    end

    // busy spans from the first element strobe until finalization, unless a new vector starts in that same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
        end else if (finalize) begin
            busy <= enableff || flag;
        end else if (enableff || flag) begin
            busy <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator. Drives the control
// strobes the way the inner-product generator does, models the operand
// memories with one cycle of read latency, and compares each result with a
// plain-arithmetic dot product. Honours DOT_SATURATE_EN when defined.
module tb_dot_product_accumulator;

    localparam int NB = 32;
    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] position = '0;
    logic          clearff = 1'b0;
    logic          enableff = 1'b0;
    logic          flag = 1'b0;
    logic [NB-1:0] addr;
    logic [NB-1:0] rd_data_a;
    logic [NB-1:0] rd_data_b;
    logic [NB-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b1;
    logic          busy;
    logic          overrun;
    logic          sat;

    logic [NB-1:0] mem_a [16];
    logic [NB-1:0] mem_b [16];

    int n_checks = 0;
    int n_fail   = 0;

    dot_product_accumulator #(
        .nBits    (NB),
        .FRAC_BITS(FB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .position    (position),
        .clearff     (clearff),
        .enableff    (enableff),
        .flag        (flag),
        .addr        (addr),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy),
        .overrun     (overrun),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    // Operand memories: data appears one cycle after the address.
    always @(posedge clk) begin
        rd_data_a <= mem_a[addr[3:0]];
        rd_data_b <= mem_b[addr[3:0]];
    end

    task automatic check_word(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact dot product of the first n elements, rescaled, then wrapped or clipped.
    function automatic void model_dot(input int n, output logic [NB-1:0] r, output logic s);
        logic signed [127:0] sum;
        logic signed [127:0] sh;
        longint              p;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            p   = longint'($signed(mem_a[i])) * longint'($signed(mem_b[i]));
            sum = sum + 128'(p);
        end
        sh = sum >>> FB;
        r  = sh[NB-1:0];
        s  = 1'b0;
`ifdef DOT_SATURATE_EN
        begin
            logic signed [127:0] hi;
            logic signed [127:0] lo;
            hi = (128'sd1 <<< (NB - 1)) - 128'sd1;
            lo = -(128'sd1 <<< (NB - 1));
            if (sh > hi) begin
                r = {1'b0, {(NB-1){1'b1}}};
                s = 1'b1;
            end else if (sh < lo) begin
                r = {1'b1, {(NB-1){1'b0}}};
                s = 1'b1;
            end
        end
`endif
    endfunction

    // One dot product over elements 0..n-1, sequenced like the control generator.
    // stress: clearff during every draining cycle and enableff alongside flag.
    task automatic run_dot(input string tag, input int n, input bit stress,
                           input bit check_t1, input logic exp_ovr);
        logic [NB-1:0] exp_r;
        logic          exp_s;
        model_dot(n, exp_r, exp_s);
        position = '0;
        clearff  = 1'b1;
        tick();
        clearff = 1'b0;
        tick();
        tick();
        for (int p = 1; p < n; p++) begin
            position = NB'(p);
            enableff = 1'b1;
            tick();
            enableff = 1'b0;
            clearff  = stress;
            tick();
            clearff = 1'b0;
            tick();
        end
        if (n > 1) check_bit({tag, "_busy_mid"}, busy, 1'b1);
        flag     = 1'b1;
        enableff = stress;
        tick();
        flag     = 1'b0;
        enableff = 1'b0;
        clearff  = stress;
        check_bit({tag, "_busy_t1"}, busy, 1'b1);
        if (check_t1) check_bit({tag, "_valid_t1"}, result_valid, 1'b0);
        tick();
        clearff = 1'b0;
        check_bit({tag, "_valid_t2"}, result_valid, 1'b1);
        check_word({tag, "_result"}, result, exp_r);
        check_bit({tag, "_sat"}, sat, exp_s);
        check_bit({tag, "_busy_done"}, busy, 1'b0);
        check_bit({tag, "_overrun"}, overrun, exp_ovr);
        if (result_ready) begin
            tick();
            check_bit({tag, "_valid_consumed"}, result_valid, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_word({tag, "_result"}, result, '0);
        check_bit({tag, "_valid"}, result_valid, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_overrun"}, overrun, 1'b0);
        check_bit({tag, "_sat"}, sat, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NB-1:0] rpos;

        // Reset state
        #1;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // addr follows position combinationally
        rpos = $urandom;
        position = rpos;
        #1;
        check_word("addr_follow", addr, rpos);
        position = '0;
        tick();

        // Single element (flag only)
        mem_a[0] = 32'h0002_0000; mem_b[0] = 32'h0003_0000;
        run_dot("single", 1, 1'b0, 1'b1, 1'b0);

        // Four elements 1..4 times 1.0
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = NB'(i + 1) << 16;
            mem_b[i] = 32'h0001_0000;
        end
        run_dot("four", 4, 1'b0, 1'b1, 1'b0);

        // Same vector with clearff during drain and enableff with flag
        run_dot("four_stress", 4, 1'b1, 1'b1, 1'b0);

        // Negative operand
        mem_a[0] = 32'hFFFE_8000; mem_b[0] = 32'h0002_0000;
        run_dot("negative", 1, 1'b0, 1'b1, 1'b0);

        // Overflowing sum: clipped or wrapped depending on the build
        mem_a[0] = 32'h7FFF_0000; mem_b[0] = 32'h7FFF_0000;
        mem_a[1] = 32'h7FFF_0000; mem_b[1] = 32'h7FFF_0000;
        run_dot("saturate", 2, 1'b0, 1'b1, 1'b0);

        // Random vectors
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                mem_a[i] = $urandom;
                mem_b[i] = (k < 3) ? NB'($signed(NB'($urandom_range(0, 32'h0008_0000))) - 32'sh0004_0000)
                                   : $urandom;
            end
            run_dot($sformatf("random%0d", k), n, k[0], 1'b1, 1'b0);
        end

        // Backpressure: two results while the consumer stalls
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = NB'(i + 1) << 16;
            mem_b[i] = 32'h0001_0000;
        end
        run_dot("bp_first", 4, 1'b0, 1'b1, 1'b0);
        mem_a[0] = 32'h0002_0000; mem_b[0] = 32'h0003_0000;
        run_dot("bp_second", 1, 1'b0, 1'b0, 1'b1);
        tick();
        check_bit("bp_held", result_valid, 1'b1);
        result_ready = 1'b1;
        tick();
        check_bit("bp_released", result_valid, 1'b0);
        check_bit("bp_overrun_sticky", overrun, 1'b1);

        // Reset in the middle of a vector
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = NB'(i + 1) << 16;
            mem_b[i] = 32'h0001_0000;
        end
        position = '0;
        clearff  = 1'b1;
        tick();
        clearff = 1'b0;
        tick();
        for (int p = 1; p < 3; p++) begin
            position = NB'(p);
            enableff = 1'b1;
            tick();
            enableff = 1'b0;
            tick();
        end
        check_bit("midreset_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        reset = 1'b1;
        position = '0;
        tick();
        tick();
        check_bit("midreset_no_partial", result_valid, 1'b0);
        run_dot("rerun", 4, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Fixed-point multiply-accumulate datapath for the pseudoinverse inner-product stage, directly downstream of the inner-product control generator. Takes that generator's `position`, `clearff`, `enableff` and `flag` outputs and drives the read address of two operand vector memories. It accumulates element products in a two-stage pipeline and presents each finished dot product through a valid/ready result port.

## Interface
- `nBits`, 32, operand and result width (signed two's complement, Q format)
- `FRAC_BITS`, 16, fractional bits of operands and result
- `clk` input 1 — rising-edge clock
- `reset` input 1 — asynchronous, active-low reset
- `position` input nBits — element index from the control generator
- `clearff` input 1 — clear accumulator
- `enableff` input 1 — accumulate the element that just finished (index `position`-1)
- `flag` input 1 — accumulate the last element (index `position`), then finalize
- `addr` output nBits — operand memory read address, combinationally equal to `position`
- `rd_data_a`, `rd_data_b` input nBits each — operand memory data, valid one cycle after `addr`
- `result` output nBits — finished dot product
- `result_valid` output 1 — `result` holds an unconsumed value
- `result_ready` input 1 — consumer accepts `result`
- `busy` output 1 — a dot product is in progress
- `overrun` output 1 — sticky; a new result overwrote an unconsumed one
- `sat` output 1 — sticky per result; the final value was clipped

## Operation
- **Reset.** All registers are zero; `result`, `result_valid`, `busy`, `overrun` and `sat` read 0.
- **Stage 1 (multiply).** In any cycle where `enableff | flag`, register `prod = rd_data_a * rd_data_b` (signed, full 2·nBits). Set `p_valid=1` and `p_last=flag`. In all other cycles `p_valid<=0`.
- **Stage 2 (accumulate).**
  - Accumulator `acc` is 2·nBits+4 bits wide and signed, giving 16 elements of guard.
  - When `p_valid && !p_last`: `acc <= acc + prod`.
  - When `p_valid && p_last`: `result <= fmt((acc + prod) >>> FRAC_BITS)`, `acc <= 0`, `result_valid <= 1`.
- **Clear.** `clearff` zeroes `acc` only in cycles where `p_valid==0`. While the pipeline is draining, `clearff` is ignored, so a final product is never lost.
- **Overrun.** If finalization occurs while `result_valid && !result_ready`, set `overrun=1` and overwrite `result`. `overrun` clears only on reset.
- **Handshake.**
  - The result is consumed on `result_valid && result_ready`.
  - `result_valid` drops the next cycle unless a finalization happens in the same cycle; in that case it stays 1 and carries the new value.
- **Busy.** `busy` rises on the first `enableff` or `flag` after idle and falls on finalization.
- **Empty vector.** `flag` with no preceding `enableff` (maximumPos=0) yields a single-product result.
- **Simultaneous inputs.** `enableff` and `flag` together are treated as `flag`.
- **Reset mid-operation.** The pipeline, `acc` and all outputs return to 0 immediately. No partial result is emitted.

## Timing
- The memory read latency is 1 cycle. `position` is stable for at least 3 cycles per element. Therefore, in a cycle with `enableff` high, `rd_data` still holds element `position`-1; in a cycle with `flag` high, it holds element `position`.
- Latency is 2 cycles from the `flag` cycle T: product registered at T+1, `result_valid` high at T+2.
- Throughput is one element per cycle maximum.

## Configuration
- Macro: `DOT_SATURATE_EN`.
- Defined: `fmt` clips to [−2^(nBits−1), 2^(nBits−1)−1] and sets `sat` when clipping occurs.
- Undefined: `fmt` takes the low nBits bits (wrap) and `sat` is tied to 0.

## Structure
- Shared package `pseudoinverse_pkg` holds:
  - default `nBits`/`FRAC_BITS`
  - the accumulator guard width constant (4)
  - the saturation bound constants
- Sub-module `dot_product_mult`: registered signed multiplier (stage 1), carrying `p_valid`/`p_last`.

## Test plan
All values are Q16.16.
1. **Single element.** maximumPos=0 (only `flag`), a=0x00020000, b=0x00030000 → `result`=0x00060000, `result_valid` at T+2.
2. **Four elements.** a=[1,2,3,4]·0x10000, b=all 0x00010000 → `result`=0x000A0000, `busy` low after finalization.
3. **Negative.** a=0xFFFE8000 (−1.5), b=0x00020000 → `result`=0xFFFD0000, `sat`=0.
4. **Saturation.** Two elements with a=b=0x7FFF0000:
   - with `DOT_SATURATE_EN` → `result`=0x7FFFFFFF, `sat`=1
   - without → wrapped low bits, `sat`=0
5. **Backpressure.** `result_ready`=0, two back-to-back dot products (10.0 then 6.0) → `overrun`=1, `result`=0x00060000; raising ready → `result_valid` falls the next cycle.
6. **Reset mid-operation.** `reset` low after 2 `enableff` pulses → all outputs 0; a rerun of scenario 2 → 0x000A0000.
